// File: rtl/dff_bist_pkg.sv
// Shared encodings and constants for the D flip-flop built-in self-test engine.
package dff_bist_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DRIVE     = 3'd1;
  localparam logic [2:0] ST_CHK_LAST  = 3'd2;
  localparam logic [2:0] ST_SET_PULSE = 3'd3;
  localparam logic [2:0] ST_SET_REL   = 3'd4;
  localparam logic [2:0] ST_CHK_CLR   = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  // x^8+x^6+x^5+x^4+1 expressed on a right-shifting register
  localparam logic [7:0] LFSR_TAPS       = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SUB   = 8'h01;
  localparam logic [7:0] FIRST_FAIL_NONE = 8'hFF;

  // An all-zero LFSR would lock up, so a zero seed is swapped for a legal one.
  function automatic logic [7:0] lfsr_seed_fix(input logic [7:0] seed);
    return (seed == 8'h00) ? LFSR_ZERO_SUB : seed;
  endfunction

endpackage

// File: rtl/dff_bist_lfsr.sv
// 8-bit Fibonacci LFSR supplying the pseudo-random data pattern for the BIST engine.
module dff_bist_lfsr
  import dff_bist_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_load,
  input  logic       i_advance,
  output logic [7:0] o_state
);

  logic [7:0] r_state;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= lfsr_seed_fix(SEED);
    end else if (i_load) begin
      r_state <= lfsr_seed_fix(SEED);
    end else if (i_advance) begin
      r_state <= {^(r_state & LFSR_TAPS), r_state[7:1]};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/dff_bist_engine.sv
// Self-test engine for a D flip-flop with active-low async set: drives data and set, checks q.
// Optional first-failure index output is enabled by defining DFF_BIST_FIRST_FAIL_EN.
module dff_bist_engine
  import dff_bist_pkg::*;
#(
  parameter int         PATTERN_LEN = 16,
  parameter int         ERR_W       = 8,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_ff_q,
  output logic             o_ff_d,
  output logic             o_ff_set_n,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count
`ifdef DFF_BIST_FIRST_FAIL_EN
  ,
  output logic [7:0]       o_first_fail_idx
`endif
);

  // state      | meaning
  // IDLE       | waiting for start after reset
  // DRIVE      | PATTERN_LEN pseudo-random bits on d, checking the previous bit
  // CHK_LAST   | d=0, check the final pattern bit
  // SET_PULSE  | set_n low, q must be 1 at the closing edge
  // SET_REL    | set_n released, FF captures d=0
  // CHK_CLR    | q must be 0
  // DONE       | result held until the next start

  localparam logic [7:0] LAST_BIT = 8'(PATTERN_LEN - 1);
  localparam logic [7:0] IDX_SET  = 8'(PATTERN_LEN);
  localparam logic [7:0] IDX_CLR  = 8'(PATTERN_LEN + 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [7:0]       r_bit_idx;
  logic             r_exp;
  logic [ERR_W-1:0] r_err;
  logic             r_set_n;
  logic [7:0]       w_lfsr;
  logic [6:0]       w_unused_lfsr_hi;
  logic             w_load;
  logic             w_advance;
  logic             w_cmp_en;
  logic             w_cmp_exp;
  logic [7:0]       w_cmp_idx;
  logic             w_mismatch;

  assign w_load    = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_advance = (r_state == ST_DRIVE);
  assign w_unused_lfsr_hi = w_lfsr[7:1];

  dff_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_load    (w_load),
    .i_advance (w_advance),
    .o_state   (w_lfsr)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (i_start) w_next_state = ST_DRIVE;
      ST_DRIVE:         if (r_bit_idx == LAST_BIT) w_next_state = ST_CHK_LAST;
      ST_CHK_LAST:      w_next_state = ST_SET_PULSE;
      ST_SET_PULSE:     w_next_state = ST_SET_REL;
      ST_SET_REL:       w_next_state = ST_CHK_CLR;
      ST_CHK_CLR:       w_next_state = ST_DONE;
      default:          w_next_state = ST_IDLE;
    endcase
  end

  // The FF has one cycle of latency, so DRIVE checks start one bit behind the driven data.
  always_comb begin
    o_ff_d    = 1'b0;
    w_cmp_en  = 1'b0;
    w_cmp_exp = 1'b0;
    w_cmp_idx = 8'd0;
    case (r_state)
      ST_DRIVE: begin
        o_ff_d    = w_lfsr[0];
        w_cmp_en  = (r_bit_idx != 8'd0);
        w_cmp_exp = r_exp;
        w_cmp_idx = r_bit_idx - 8'd1;
      end
      ST_CHK_LAST: begin
        w_cmp_en  = 1'b1;
        w_cmp_exp = r_exp;
        w_cmp_idx = LAST_BIT;
      end
      ST_SET_PULSE: begin
        w_cmp_en  = 1'b1;
        w_cmp_exp = 1'b1;
        w_cmp_idx = IDX_SET;
      end
      ST_CHK_CLR: begin
        w_cmp_en  = 1'b1;
        w_cmp_exp = 1'b0;
        w_cmp_idx = IDX_CLR;
      end
      default: ;
    endcase
  end

  assign w_mismatch  = w_cmp_en && (i_ff_q != w_cmp_exp);
  assign o_busy      = !(r_state == ST_IDLE || r_state == ST_DONE);
  assign o_done      = (r_state == ST_DONE);
  assign o_pass      = o_done && (r_err == '0);
  assign o_err_count = r_err;
  assign o_ff_set_n  = r_set_n;

  // set_n is decoded from the next state so the pin comes straight off a flop.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bit_idx <= 8'd0;
      r_exp     <= 1'b0;
      r_err     <= '0;
      r_set_n   <= 1'b1;
    end else begin
      r_set_n <= (w_next_state != ST_SET_PULSE);
      if (w_load) begin
        r_bit_idx <= 8'd0;
        r_exp     <= 1'b0;
        r_err     <= '0;
      end else begin
        if (r_state == ST_DRIVE) begin
          r_bit_idx <= r_bit_idx + 8'd1;
          r_exp     <= w_lfsr[0];
        end
        if (w_mismatch && (r_err != {ERR_W{1'b1}})) r_err <= r_err + ERR_W'(1);
      end
    end
  end

`ifdef DFF_BIST_FIRST_FAIL_EN
  logic [7:0] r_first_fail;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_first_fail <= FIRST_FAIL_NONE;
    end else if (w_load) begin
      r_first_fail <= FIRST_FAIL_NONE;
    end else if (w_mismatch && (r_first_fail == FIRST_FAIL_NONE)) begin
      r_first_fail <= w_cmp_idx;
    end
  end

  assign o_first_fail_idx = r_first_fail;
`else
  logic [7:0] w_unused_cmp_idx;
  assign w_unused_cmp_idx = w_cmp_idx;
`endif

endmodule

// File: tb/tb_dff_bist_engine.sv
// Directed bench for dff_bist_engine: behavioural async-set DFF as the cell under test.
module tb_dff_bist_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ff_q, ff_d, ff_set_n;
  logic       busy, done, pass;
  logic [7:0] err;
  logic       model_q;
  int         mode;

  logic       start2;
  logic       ff_q2, ff_d2, ff_set_n2;
  logic       busy2, done2, pass2;
  logic [1:0] err2;
  logic       model2_q;

`ifdef DFF_BIST_FIRST_FAIL_EN
  logic [7:0] ffi;
  logic [7:0] ffi2;
`endif

  int n_vec = 0;
  int n_err = 0;
  int setn_lows = 0;
  int n;

  always #5 clk = ~clk;

  // FF under test: 0 = healthy, 1 = q stuck at 0, 2 = q stuck at 1
  always @(posedge clk or negedge ff_set_n)
    if (!ff_set_n) model_q <= 1'b1;
    else           model_q <= ff_d;
  assign ff_q = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : model_q;

  always @(posedge clk or negedge ff_set_n2)
    if (!ff_set_n2) model2_q <= 1'b1;
    else            model2_q <= ff_d2;
  assign ff_q2 = ~model2_q;

  always @(negedge clk) if (!ff_set_n) setn_lows <= setn_lows + 1;

  dff_bist_engine dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_start     (start),
    .i_ff_q      (ff_q),
    .o_ff_d      (ff_d),
    .o_ff_set_n  (ff_set_n),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_err_count (err)
`ifdef DFF_BIST_FIRST_FAIL_EN
    ,
    .o_first_fail_idx (ffi)
`endif
  );

  dff_bist_engine #(.ERR_W(2)) dut2 (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_start     (start2),
    .i_ff_q      (ff_q2),
    .o_ff_d      (ff_d2),
    .o_ff_set_n  (ff_set_n2),
    .o_busy      (busy2),
    .o_done      (done2),
    .o_pass      (pass2),
    .o_err_count (err2)
`ifdef DFF_BIST_FIRST_FAIL_EN
    ,
    .o_first_fail_idx (ffi2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after the sampling edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Edges counted from the start-sampling edge until done is seen (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 60) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    mode   = 0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err, 0);
    check("rst_ff_d", ff_d, 0);
    check("rst_set_n", ff_set_n, 1);
`ifdef DFF_BIST_FIRST_FAIL_EN
    check("rst_ffi", ffi, 8'hFF);
`endif
    rst_n = 1'b1;

    // healthy FF
    @(negedge clk);
    setn_lows = 0;
    pulse_start();
    check("good_busy_next", busy, 1);
    wait_done(n);
    check("good_done_cycle", n, 20);
    check("good_pass", pass, 1);
    check("good_err", err, 0);
    check("good_setn_lows", setn_lows, 1);
`ifdef DFF_BIST_FIRST_FAIL_EN
    check("good_ffi", ffi, 8'hFF);
`endif
    repeat (3) @(negedge clk);
    check("good_done_held", done, 1);
    check("good_busy_after", busy, 0);

    // q stuck at 0: 7 ones in the pattern plus the set check
    mode = 1;
    pulse_start();
    wait_done(n);
    check("sa0_done_cycle", n, 20);
    check("sa0_err", err, 8);
    check("sa0_pass", pass, 0);
`ifdef DFF_BIST_FIRST_FAIL_EN
    check("sa0_ffi", ffi, 8'd0);
`endif

    // q stuck at 1: 9 zeros in the pattern plus the clear check
    mode = 2;
    pulse_start();
    check("sa1_done_cleared", done, 0);
    wait_done(n);
    check("sa1_err", err, 10);
    check("sa1_pass", pass, 0);
`ifdef DFF_BIST_FIRST_FAIL_EN
    check("sa1_ffi", ffi, 8'd1);
`endif

    // abort at DRIVE i=5 with stuck-at-0 so partial results are non-zero
    mode = 1;
    pulse_start();
    repeat (5) @(negedge clk);
    check("abort_pre_err", err, 2);
    check("abort_pre_ff_d", ff_d, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_err", err, 0);
    check("abort_ff_d", ff_d, 0);
    check("abort_set_n", ff_set_n, 1);
    mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    wait_done(n);
    check("restart_done_cycle", n, 20);
    check("restart_pass", pass, 1);

    // start held high across the run
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("hold_busy", busy, 1);
    wait_done(n);
    check("hold_done_cycle", n, 20);
    check("hold_pass", pass, 1);
    @(negedge clk);
    check("hold_rerun_busy", busy, 1);
    check("hold_rerun_done", done, 0);
    start = 1'b0;
    wait_done(n);
    check("hold_rerun_cycle", n, 20);

    // ERR_W=2 with inverted q: every compare fails, counter saturates at 3
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("sat_busy", busy2, 1);
    repeat (3) @(negedge clk);
    check("sat_err_2", err2, 2);
    repeat (5) @(negedge clk);
    check("sat_err_3", err2, 3);
    n = 8;
    while (!done2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("sat_done_cycle", n, 20);
    check("sat_err_final", err2, 3);
    check("sat_pass", pass2, 0);
`ifdef DFF_BIST_FIRST_FAIL_EN
    check("sat_ffi", ffi2, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
